// File: rtl/minisrc_shift_pkg.sv
// Shared definitions for the sequential shifter: operation codes, FSM states
// and the legality check used to decide whether an operation is carried out.
package minisrc_shift_pkg;

    typedef enum logic [2:0] {
        OP_SHR  = 3'd0,
        OP_SHRA = 3'd1,
        OP_SHL  = 3'd2,
        OP_ROR  = 3'd3,
        OP_ROL  = 3'd4
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_e;

    function automatic logic op_is_legal(input logic [2:0] op_code);
        if (op_code <= 3'd4) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves the value by k positions for the
// selected operation. Unknown codes pass the value through untouched.
module shift_step
    import minisrc_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int K_W   = 6
) (
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       op,
    input  logic [K_W-1:0]   k,
    output logic [WIDTH-1:0] shifted
);

    logic [K_W-1:0] inv_k_s;

    // complementary distance for the wrap-around half of a rotate
    always_comb begin
        inv_k_s = K_W'(WIDTH) - k;
    end

    // per-operation shift of the working value
    always_comb begin
        shifted = value;
        case (op)
            OP_SHR:  shifted = value >> k;
            OP_SHRA: shifted = $signed(value) >>> k;
            OP_SHL:  shifted = value << k;
            OP_ROR:  shifted = (value >> k) | (value << inv_k_s);
            OP_ROL:  shifted = (value << k) | (value >> inv_k_s);
            default: shifted = value;
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: accepts an operand and count, shifts up to STEP
// positions per clock, and pulses done (with err for illegal ops) at the end.
module seq_shift_unit
    import minisrc_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int K_W = AMT_W + 1;

    shift_state_e     state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [2:0]       op_q, op_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [K_W-1:0]   k_s;
    logic [WIDTH-1:0] step_out_s;
    logic             amount_unused_s;

    assign amount_unused_s = ^amount[WIDTH-1:AMT_W];

    shift_step #(
        .WIDTH (WIDTH),
        .K_W   (K_W)
    ) u_shift_step (
        .value   (work_q),
        .op      (op_q),
        .k       (k_s),
        .shifted (step_out_s)
    );

    // step size for this cycle: the lesser of STEP and what is left
    always_comb begin
        if ({1'b0, rem_q} > K_W'(STEP)) begin
            k_s = K_W'(STEP);
        end else begin
            k_s = {1'b0, rem_q};
        end
    end

    // next-state, working register and counter update
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        op_d    = op_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    work_d = data_in;
                    op_d   = op;
                    rem_d  = amount[AMT_W-1:0];
                    if ((amount[AMT_W-1:0] == {AMT_W{1'b0}}) || !op_is_legal(op)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_d = step_out_s;
                rem_d  = rem_q - k_s[AMT_W-1:0];
                if ({1'b0, rem_q} == k_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state register with asynchronous clear
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            work_q  <= {WIDTH{1'b0}};
            op_q    <= 3'd0;
            rem_q   <= {AMT_W{1'b0}};
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
        end
    end

    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign err    = (state_q == ST_DONE) && !op_is_legal(op_q);
    assign result = work_q;

endmodule

// File: doc/seq_shift_unit.md
SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath operand/result width in bits.
REQ-002 SHALL have parameter STEP, default 4: maximum bit positions shifted per clock; legal range 1..WIDTH.
REQ-003 SHALL have parameter AMT_W, default log2(WIDTH): significant shift-amount bits.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port clr  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  request pulse; sampled on rising clk edge.
REQ-007 SHALL have port op  input  3  operation select: SHR, SHRA, SHL, ROR, ROL; other codes illegal.
REQ-008 SHALL have port data_in  input  WIDTH  operand to shift.
REQ-009 SHALL have port amount  input  WIDTH  shift count; only bits [AMT_W-1:0] used, upper bits ignored.
REQ-010 SHALL have port busy  output  1  high while operation in progress.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  one-cycle pulse coincident with done for illegal op.
REQ-013 SHALL have port result  output  WIDTH  shifted value; valid when done high, held until next accepted start.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 IDLE or DONE with start=1: SHALL latch data_in, op, amount[AMT_W-1:0] into working register, op register and remaining counter.
REQ-016 On accept with remaining=0 or illegal op: SHALL go directly to DONE; otherwise to SHIFT.
REQ-017 SHIFT: each edge SHALL shift working register by k=min(STEP, remaining) and decrement remaining by k; go to DONE when remaining reaches 0.
REQ-018 done SHALL rise ceil(amt/STEP) edges after the start-sampling edge (amt=0: right after that edge); high exactly one cycle.
REQ-019 DONE SHALL return to IDLE next edge unless start=1, which is accepted per REQ-015 (back-to-back).
REQ-020 SHR SHALL zero-fill from MSB; SHRA SHALL replicate original bit WIDTH-1; SHL SHALL zero-fill from LSB; ROR/ROL SHALL rotate within WIDTH.
REQ-021 Illegal op: result SHALL equal data_in unchanged; err=1 with done.
REQ-022 busy SHALL be high in SHIFT only; start while busy SHALL be ignored without affecting the in-flight operation.
REQ-023 result SHALL be driven from the working register; it SHALL not change in IDLE.

Reset
REQ-024 clr=0 SHALL immediately force state IDLE, busy=0, done=0, err=0, result=0, remaining=0, independent of clk.
REQ-025 clr asserted mid-SHIFT SHALL abort the operation with no done pulse; first start after clr release SHALL be accepted normally.

Structure
REQ-026 Op encodings (SHR=0, SHRA=1, SHL=2, ROR=3, ROL=4) and FSM state encodings SHALL live in shared package minisrc_shift_pkg.
REQ-027 Per-cycle shift SHALL be a combinational sub-module shift_step (inputs value, op, k; output shifted value), instantiated once.
REQ-028 Only FSM, working register, op register and remaining counter SHALL be sequential; no latches.

Verification
REQ-029 SHRA, data_in=0x8000FA92, amount=0xA, STEP=4 -> result=0xFFE0003E, done 3 edges after start, busy high 3 cycles.
REQ-030 SHR, data_in=0x8000FA92, amount=0xA -> result=0x0020003E, err=0.
REQ-031 SHL, data_in=0x00000001, amount=31 -> result=0x80000000 after 8 edges; ROL, 0x80000001, amount=1 -> 0x00000003.
REQ-032 Any op, amount=0x20 (low 5 bits 0), data_in=0x12345678 -> result=0x12345678, done right after start edge; op=7 -> same result with err=1.
REQ-033 start with new operands while busy -> ignored, original result delivered; start in DONE cycle -> second operation accepted back-to-back.
REQ-034 clr pulsed low mid-SHIFT -> busy/done/result 0 immediately, no done pulse; next start completes correctly.
